bp_tree_switch: RTL and testbench

Backpressure (valid/ready) switch for the butterfly-fat-tree NoC: the backpressure counterpart to the credit-based switches, generalised to one or two up-links so a single module serves as both T switch (NUM_UP=1) and Pi switch (NUM_UP=2). Each input is buffered in a FIFO, routed by destination address against the switch's level/position, and arbitrated round-robin per output with grant locking so transmitted flits stay stable under backpressure. Sits at every internal tree node between client/lower-level links (l, r) and upper-level links (u).

---
 rtl/bp_tree_switch.sv | 182 ++++++++++++++++++
 tb/tb_bp_tree_switch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_tree_switch.sv
// Valid/ready butterfly-fat-tree switch (T when NUM_UP=1, Pi when NUM_UP=2).
// Optional per-output stall counters: define BP_TREE_SWITCH_STATS_EN.
module bp_tree_switch #(
  parameter int N          = 8,
  parameter int A_W        = 3,
  parameter int D_W        = 8,
  parameter int posl       = 0,
  parameter int posx       = 0,
  parameter int NUM_UP     = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int F_W       = A_W + D_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       l_rx_valid,
  output logic                       l_rx_ready,
  input  logic [F_W-1:0]             l_rx_data,
  input  logic                       r_rx_valid,
  output logic                       r_rx_ready,
  input  logic [F_W-1:0]             r_rx_data,
  input  logic [NUM_UP-1:0]          u_rx_valid,
  output logic [NUM_UP-1:0]          u_rx_ready,
  input  logic [NUM_UP*F_W-1:0]      u_rx_data,
  output logic                       l_tx_valid,
  input  logic                       l_tx_ready,
  output logic [F_W-1:0]             l_tx_data,
  output logic                       r_tx_valid,
  input  logic                       r_tx_ready,
  output logic [F_W-1:0]             r_tx_data,
  output logic [NUM_UP-1:0]          u_tx_valid,
  input  logic [NUM_UP-1:0]          u_tx_ready,
  output logic [NUM_UP*F_W-1:0]      u_tx_data,
  output logic [(2+NUM_UP)*16-1:0]   stall_cnt
);

  localparam int P  = 2 + NUM_UP;
  localparam int AW = $clog2(FIFO_DEPTH);

  if (NUM_UP < 1 || NUM_UP > 2) begin : g_bad_up
    $error("bp_tree_switch: NUM_UP must be 1 or 2");
  end
  if ((1 << A_W) < N) begin : g_bad_aw
    $error("bp_tree_switch: A_W too small for N clients");
  end

  logic [P-1:0]   in_v, in_r, hv, pop;
  logic [P-1:0]   out_v, out_r;
  logic [F_W-1:0] in_d  [P];
  logic [F_W-1:0] head  [P];
  logic [F_W-1:0] out_d [P];
  logic [1:0]     tgt   [P];
  logic [1:0]     win   [P];
  logic [P-1:0]   req   [P];

  assign in_v  = {u_rx_valid, r_rx_valid, l_rx_valid};
  assign out_r = {u_tx_ready, r_tx_ready, l_tx_ready};

  assign l_rx_ready = in_r[0];
  assign r_rx_ready = in_r[1];
  assign u_rx_ready = in_r[P-1:2];
  assign l_tx_valid = out_v[0];
  assign r_tx_valid = out_v[1];
  assign u_tx_valid = out_v[P-1:2];
  assign l_tx_data  = out_d[0];
  assign r_tx_data  = out_d[1];
  assign in_d[0]    = l_rx_data;
  assign in_d[1]    = r_rx_data;

  for (genvar j = 0; j < NUM_UP; j++) begin : g_up
    assign in_d[2+j] = u_rx_data[j*F_W +: F_W];
    assign u_tx_data[j*F_W +: F_W] = out_d[2+j];
  end

  for (genvar i = 0; i < P; i++) begin : g_in
    logic [F_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    cnt;
    logic           push, near;
    logic [A_W-1:0] dest;
    logic [1:0]     t;

    // ready comes from registered occupancy only
    assign in_r[i]  = !rst && (cnt != (AW+1)'(FIFO_DEPTH));
    assign push     = in_v[i] && in_r[i];
    assign hv[i]    = cnt != '0;
    assign head[i]  = mem[rp];
    assign dest     = head[i][F_W-1:D_W];
    assign near     = (dest >> (posl + 1)) == A_W'(posx);
    assign tgt[i]   = t;

    always_ff @(posedge clk) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          mem[wp] <= in_d[i];
          wp      <= wp + AW'(1);
        end
        if (pop[i]) rp <= rp + AW'(1);
        case ({push, pop[i]})
          2'b10:   cnt <= cnt + (AW+1)'(1);
          2'b01:   cnt <= cnt - (AW+1)'(1);
          default: ;
        endcase
      end
    end

    // up inputs that miss the subtree still follow dest[posl]
    always_comb begin
      t = 2'd0;
      unique case (1'b1)
        near || (i >= 2):  t = {1'b0, dest[posl]};
        !near && (i == 0): t = 2'd2;
        default:           t = 2'(P - 1);
      endcase
    end
  end

  always_comb begin
    for (int o = 0; o < P; o++) begin
      for (int i = 0; i < P; i++) begin
        req[o][i] = hv[i] && (tgt[i] == 2'(o));
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < P; o++) begin
      if (out_v[o] && out_r[o]) pop[win[o]] = 1'b1;
    end
  end

  for (genvar o = 0; o < P; o++) begin : g_out
    logic [1:0] ptr, lwin, pick;
    logic       lock;

    // reverse scan: nearest requester at or after ptr wins
    always_comb begin
      pick = ptr;
      for (int s = P - 1; s >= 0; s--) begin
        int j;
        j = int'(ptr) + s;
        if (j >= P) j = j - P;
        if (req[o][j]) pick = 2'(j);
      end
      if (lock) pick = lwin;
    end

    assign win[o]   = pick;
    assign out_v[o] = !rst && (|req[o]);
    assign out_d[o] = head[pick];

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr  <= '0;
        lwin <= '0;
        lock <= 1'b0;
      end else if (out_v[o] && out_r[o]) begin
        ptr  <= (pick == 2'(P - 1)) ? 2'd0 : pick + 2'd1;
        lock <= 1'b0;
      end else begin
        lock <= out_v[o];
        lwin <= pick;
      end
    end

`ifdef BP_TREE_SWITCH_STATS_EN
    logic [15:0] sc;
    always_ff @(posedge clk) begin
      if (rst) sc <= '0;
      else if (out_v[o] && !out_r[o] && sc != 16'hFFFF) sc <= sc + 16'd1;
    end
    assign stall_cnt[o*16 +: 16] = sc;
`else
    assign stall_cnt[o*16 +: 16] = 16'd0;
`endif
  end

endmodule

// File: tb/tb_bp_tree_switch.sv
// Bench for bp_tree_switch: T and Pi instances share stimulus and are
// checked every cycle against a queue-based model plus literal expectations.
module tb_bp_tree_switch;
  localparam int A_W   = 3;
  localparam int D_W   = 8;
  localparam int F_W   = 11;
  localparam int POSL  = 1;
  localparam int POSX  = 0;
  localparam int DEPTH = 4;
`ifdef BP_TREE_SWITCH_STATS_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [3:0]       rxv = '0;
  logic [3:0]       txr = 4'hF;
  logic [3:0][10:0] rxd = '0;

  logic [3:0]       v0, v1, rdy0, rdy1;
  logic [3:0][10:0] d0, d1;
  logic [3:0][15:0] s0, s1;

  int checks = 0;
  int errs   = 0;

  assign v0[3]   = 1'b0;
  assign rdy0[3] = 1'b0;
  assign d0[3]   = '0;
  assign s0[3]   = '0;

  bp_tree_switch #(
    .N(8), .A_W(A_W), .D_W(D_W), .posl(POSL), .posx(POSX),
    .NUM_UP(1), .FIFO_DEPTH(DEPTH)
  ) dut_t (
    .clk(clk), .rst(rst),
    .l_rx_valid(rxv[0]), .l_rx_ready(rdy0[0]), .l_rx_data(rxd[0]),
    .r_rx_valid(rxv[1]), .r_rx_ready(rdy0[1]), .r_rx_data(rxd[1]),
    .u_rx_valid(rxv[2]), .u_rx_ready(rdy0[2]), .u_rx_data(rxd[2]),
    .l_tx_valid(v0[0]), .l_tx_ready(txr[0]), .l_tx_data(d0[0]),
    .r_tx_valid(v0[1]), .r_tx_ready(txr[1]), .r_tx_data(d0[1]),
    .u_tx_valid(v0[2]), .u_tx_ready(txr[2]), .u_tx_data(d0[2]),
    .stall_cnt(s0[2:0])
  );

  bp_tree_switch #(
    .N(8), .A_W(A_W), .D_W(D_W), .posl(POSL), .posx(POSX),
    .NUM_UP(2), .FIFO_DEPTH(DEPTH)
  ) dut_pi (
    .clk(clk), .rst(rst),
    .l_rx_valid(rxv[0]), .l_rx_ready(rdy1[0]), .l_rx_data(rxd[0]),
    .r_rx_valid(rxv[1]), .r_rx_ready(rdy1[1]), .r_rx_data(rxd[1]),
    .u_rx_valid(rxv[3:2]), .u_rx_ready(rdy1[3:2]), .u_rx_data(rxd[3:2]),
    .l_tx_valid(v1[0]), .l_tx_ready(txr[0]), .l_tx_data(d1[0]),
    .r_tx_valid(v1[1]), .r_tx_ready(txr[1]), .r_tx_data(d1[1]),
    .u_tx_valid(v1[3:2]), .u_tx_ready(txr[3:2]), .u_tx_data(d1[3:2]),
    .stall_cnt(s1)
  );

  task automatic chk(input string nm, input int k, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s dut%0d[%0d]: got %0h expected %0h", nm, k, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // destination-based output choice for a flit at input i of instance k
  function automatic int route(int k, int i, logic [10:0] f);
    logic [2:0] d;
    bit near;
    d = f[10:8];
    near = (int'(d) >> (POSL + 1)) == POSX;
    if (near || i >= 2) return d[POSL] ? 1 : 0;
    if (i == 0) return 2;
    return 2 + k;
  endfunction

  logic [10:0] mq [2][4][$];
  int mptr  [2][4];
  bit mlock [2][4];
  int mlw   [2][4];
  int mst   [2][4];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int np;
      bit ev [4];
      int ew [4];
      bit er [4];
      np = 3 + k;
      for (int i = 0; i < 4; i++) begin
        ev[i] = 0;
        ew[i] = 0;
        er[i] = 0;
      end
      for (int i = 0; i < np; i++) er[i] = !rst && mq[k][i].size() < DEPTH;
      if (!rst) begin
        for (int o = 0; o < np; o++) begin
          if (mlock[k][o]) begin
            ev[o] = 1;
            ew[o] = mlw[k][o];
          end else begin
            for (int s = 0; s < np && !ev[o]; s++) begin
              int j;
              j = (mptr[k][o] + s) % np;
              if (mq[k][j].size() > 0 && route(k, j, mq[k][j][0]) == o) begin
                ev[o] = 1;
                ew[o] = j;
              end
            end
          end
        end
      end
      if (en) begin
        for (int o = 0; o < np; o++) begin
          chk("tx_valid", k, o, k == 0 ? v0[o] : v1[o], ev[o]);
          if (ev[o])
            chk("tx_data", k, o, k == 0 ? d0[o] : d1[o], mq[k][ew[o]][0]);
          chk("stall_cnt", k, o, k == 0 ? s0[o] : s1[o], mst[k][o]);
          chk("rx_ready", k, o, k == 0 ? rdy0[o] : rdy1[o], er[o]);
        end
      end
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          mq[k][i].delete();
          mptr[k][i]  = 0;
          mlock[k][i] = 0;
          mst[k][i]   = 0;
        end
      end else begin
        for (int o = 0; o < np; o++) begin
          if (ev[o] && txr[o]) begin
            mptr[k][o]  = (ew[o] + 1) % np;
            mlock[k][o] = 0;
          end else if (ev[o]) begin
            mlock[k][o] = 1;
            mlw[k][o]   = ew[o];
`ifdef BP_TREE_SWITCH_STATS_EN
            if (mst[k][o] < 65535) mst[k][o]++;
`endif
          end else begin
            mlock[k][o] = 0;
          end
        end
        for (int o = 0; o < np; o++)
          if (ev[o] && txr[o]) void'(mq[k][ew[o]].pop_front());
        for (int i = 0; i < np; i++)
          if (rxv[i] && er[i]) mq[k][i].push_back(rxd[i]);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    logic acc;
    step();
    en = 1'b1;
    chk("rst_tx_valid", 0, 0, v0, 4'b0000);
    chk("rst_rx_ready", 1, 0, rdy1, 4'b0000);
    rst = 1'b0;
    step();

    // local route: l -> r, one cycle latency
    rxd[0] = 11'h2A5;
    rxv[0] = 1'b1;
    step();
    rxv[0] = 1'b0;
    chk("loc_outs", 0, 1, v0[2:0], 3'b010);
    chk("loc_data", 0, 1, d0[1], 11'h2A5);
    chk("loc_data", 1, 1, d1[1], 11'h2A5);
    step();

    // up route: l -> u0, r -> u1 (Pi) or u0 (T)
    rxd[0] = 11'h411;
    rxd[1] = 11'h422;
    rxv[1:0] = 2'b11;
    step();
    rxv[1:0] = 2'b00;
    chk("up_valid", 1, 2, v1[3:2], 2'b11);
    chk("up_u0", 1, 2, d1[2], 11'h411);
    chk("up_u1", 1, 3, d1[3], 11'h422);
    chk("up_t_first", 0, 2, d0[2], 11'h411);
    step();
    chk("up_t_second", 0, 2, d0[2], 11'h422);
    step();

    // contention for r from pointer 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    rxd[0] = 11'h231;
    rxd[2] = 11'h232;
    rxv[0] = 1'b1;
    rxv[2] = 1'b1;
    step();
    rxv = '0;
    chk("cont_first", 0, 1, d0[1], 11'h231);
    step();
    chk("cont_second", 0, 1, d0[1], 11'h232);
    chk("cont_second", 1, 1, d1[1], 11'h232);
    step();

    // backpressure: six flits into a four-deep FIFO with r stalled
    txr[1] = 1'b0;
    sent = 0;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      rxd[0] = 11'h250 + 11'(sent);
      rxv[0] = 1'b1;
      acc = rdy0[0];
      step();
      if (acc) sent++;
    end
    rxd[0] = 11'h250 + 11'(sent);
    chk("bp_accepted", 0, 0, sent, 4);
    chk("bp_full", 0, 0, rdy0[0], 1'b0);
    chk("bp_hold", 0, 1, d0[1], 11'h250);
    repeat (2) step();
    chk("bp_stable", 0, 1, d0[1], 11'h250);
    txr[1] = 1'b1;
    for (int c = 0; c < 20 && sent < 6; c++) begin
      rxd[0] = 11'h250 + 11'(sent);
      rxv[0] = 1'b1;
      acc = rdy0[0];
      step();
      if (acc) sent++;
    end
    rxv[0] = 1'b0;
    chk("bp_total", 0, 0, sent, 6);
    repeat (6) step();

    // grant lock: u0 arrives while l is stalled on r
    txr[1] = 1'b0;
    rxd[0] = 11'h2C1;
    rxv[0] = 1'b1;
    step();
    rxv[0] = 1'b0;
    step();
    rxd[2] = 11'h2C2;
    rxv[2] = 1'b1;
    step();
    rxv[2] = 1'b0;
    step();
    chk("lock_hold", 0, 1, d0[1], 11'h2C1);
    chk("lock_hold", 1, 1, d1[1], 11'h2C1);
    txr[1] = 1'b1;
    step();
    chk("lock_next", 0, 1, d0[1], 11'h2C2);
    step();
    step();

    // stall counting then mid-operation reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    txr[1] = 1'b0;
    rxd[0] = 11'h2D1;
    rxv[0] = 1'b1;
    step();
    rxd[0] = 11'h2D2;
    step();
    rxv[0] = 1'b0;
    repeat (4) step();
    chk("stall_r", 0, 1, s0[1], STALL_EXP);
    chk("stall_r", 1, 1, s1[1], STALL_EXP);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", 0, 0, v0, 4'b0000);
    chk("rst_mid_ready", 0, 0, rdy0, 4'b0000);
    rst = 1'b0;
    step();
    chk("post_rst_stall", 0, 1, s0[1], 0);
    chk("post_rst_valid", 1, 0, v1, 4'b0000);
    chk("post_rst_ready", 0, 0, rdy0[2:0], 3'b111);
    txr = 4'hF;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
